// File: rtl/echo_responder.sv
// Responder end of the echo request/indication protocol: buffers say(v) words
// in a FIFO and returns each via heard(v) after a turnaround delay, seq-tagged.
module echo_responder #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int DELAY = 2
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     say__ENA,
    input  logic [WIDTH-1:0]         say_v,
    output logic                     say__RDY,
    output logic                     heard__ENA,
    output logic [WIDTH-1:0]         heard_v,
    output logic [7:0]               heard_seq,
    input  logic                     heard__RDY,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SEND
    } state_t;

    state_t           r_state;
    logic [7:0]       r_dly;
    logic [7:0]       r_seq;
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_full;
    logic w_send;
    logic w_enq;
    logic w_deq;

    // Ready looks only at registered occupancy, so a same-cycle dequeue
    // never frees a slot for a full FIFO.
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_send   = (r_state == SEND);
    assign say__RDY = nRST && !w_full;
    assign w_enq    = say__ENA && say__RDY;
    assign w_deq    = nRST && w_send && heard__RDY;

    assign heard__ENA = w_deq;
    assign heard_v    = (nRST && w_send) ? r_mem[r_rd] : '0;
    assign heard_seq  = (nRST && w_send) ? r_seq : 8'd0;
    assign count      = r_count;

    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_mem[r_wr] <= say_v;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_deq) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_dly   <= 8'd0;
            r_seq   <= 8'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (r_count != '0) begin
                        r_dly   <= 8'(DELAY);
                        r_state <= (DELAY == 0) ? SEND : HOLD;
                    end
                end
                HOLD: begin
                    r_dly <= r_dly - 8'd1;
                    if (r_dly == 8'd1) begin
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (heard__RDY) begin
                        r_seq   <= r_seq + 8'd1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_echo_responder.sv
// Randomized bench for echo_responder against a queue-and-timing reference
// model of the echo protocol (DELAY=2, DEPTH=4).
module tb_echo_responder;

    localparam int D = 2;
    localparam int N = 4;

    logic        CLK;
    logic        nRST;
    logic        say__ENA;
    logic [31:0] say_v;
    logic        say__RDY;
    logic        heard__ENA;
    logic [31:0] heard_v;
    logic [7:0]  heard_seq;
    logic        heard__RDY;
    logic [2:0]  count;

    echo_responder #(.WIDTH(32), .DEPTH(N), .DELAY(D)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .say__ENA   (say__ENA),
        .say_v      (say_v),
        .say__RDY   (say__RDY),
        .heard__ENA (heard__ENA),
        .heard_v    (heard_v),
        .heard_seq  (heard_seq),
        .heard__RDY (heard__RDY),
        .count      (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] d;
        int          c;
    } ent_t;

    ent_t       q[$];
    logic [7:0] m_seq;
    int         last_fire;
    int         cyc;
    int         n_chk;
    int         n_fail;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h expected %h",
                     tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive, check at negedge, advance the model at posedge.
    task automatic step(input logic rst_n, input logic ena,
                        input logic [31:0] v, input logic rdy);
        bit insend;
        bit exp_rdy;
        int e;
        nRST       = rst_n;
        say__ENA   = ena;
        say_v      = v;
        heard__RDY = rdy;
        @(negedge CLK);
        insend = 1'b0;
        if (rst_n && q.size() > 0) begin
            e = q[0].c + 2 + D;
            if (last_fire + 2 + D > e) e = last_fire + 2 + D;
            insend = (cyc >= e);
        end
        exp_rdy = rst_n && (q.size() < N);
        chk("say_rdy", 32'(say__RDY), 32'(exp_rdy));
        chk("heard_ena", 32'(heard__ENA), 32'(insend && rdy));
        chk("heard_v", heard_v, insend ? q[0].d : 32'd0);
        chk("heard_seq", 32'(heard_seq), insend ? 32'(m_seq) : 32'd0);
        chk("count", 32'(count), 32'(q.size()));
        if (!rst_n) begin
            q.delete();
            m_seq     = 8'd0;
            last_fire = -100;
        end else begin
            if (insend && rdy) begin
                void'(q.pop_front());
                m_seq     = m_seq + 8'd1;
                last_fire = cyc;
            end
            if (ena && exp_rdy) q.push_back('{v, cyc});
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        cyc        = 0;
        m_seq      = 8'd0;
        last_fire  = -100;
        nRST       = 1'b0;
        say__ENA   = 1'b1;
        say_v      = 32'h0;
        heard__RDY = 1'b1;
        @(posedge CLK);
        #1;

        // reset held with say__ENA asserted
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h1111_0000, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);

        // single echo
        while (cyc < 10) step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

        // fill with sink stalled, 5th say ignored, then drain
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 32'(i), 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

        // backpressure in SEND
        step(1'b1, 1'b1, 32'hA5A5_0001, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

        // reset mid-SEND with three words queued
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'hC0DE_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

        // random traffic long enough to wrap the sequence counter
        for (int i = 0; i < 2000; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), $urandom,
                 ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
